// File: rtl/seven_seg_scan_if.sv
// Scan bus as seen by the seven-segment display: column strobes + digit code.
// master: scan driver (drives col_n, data_in); slave: capture/monitor side.
interface seven_seg_scan_if;
  logic [7:0] col_n;
  logic [3:0] data_in;

  modport master (
    output col_n,
    output data_in
  );

  modport slave (
    input col_n,
    input data_in
  );
endinterface

// File: rtl/seven_seg_scan_capture.sv
// Scan-bus capture: checks column order, rebuilds an 8-column frame and
// recovers sum/candy_sum. Ports: clk, reset (async, high), bus (slave:
// col_n active-low strobes, data_in), sum, candy_sum, frame_valid, locked,
// seq_err, err_count. Define SCAN_CAP_CONTENT_CHECK_EN for digit checks.
module seven_seg_scan_capture #(
  parameter int TIMEOUT = 16,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  seven_seg_scan_if.slave  bus,
  output logic [7:0]       sum,
  output logic [2:0]       candy_sum,
  output logic             frame_valid,
  output logic             locked,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    HUNT,
    CAPTURE
  } state_t;

  state_t        state;
  logic [7:0]    col_q;
  logic [3:0]    dat_q;
  logic [3:0]    fbuf [8];
  logic [2:0]    exp_idx;
  logic [TW-1:0] tmo;

  logic          blank;
  logic          valid;
  logic [2:0]    idx;
  logic [3:0]    nlow;
  logic          ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q <= 8'hFF;
      dat_q <= 4'h0;
    end else begin
      col_q <= bus.col_n;
      dat_q <= bus.data_in;
    end
  end

  always_comb begin
    blank = (col_q == 8'hFF);
    nlow  = 4'd0;
    idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!col_q[i]) begin
        nlow = nlow + 4'd1;
        idx  = 3'(i);
      end
    end
    valid = (nlow == 4'd1);
  end

`ifdef SCAN_CAP_CONTENT_CHECK_EN
  always_comb begin
    ok = 1'b1;
    case (idx)
      3'd0, 3'd1:       ok = (dat_q == 4'h0);
      3'd4, 3'd6, 3'd7: ok = (dat_q == 4'hA);
      3'd5:             ok = !dat_q[3];
      default:          ok = 1'b1;
    endcase
  end
`else
  always_comb begin
    ok = 1'b1;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= HUNT;
      exp_idx     <= 3'd0;
      tmo         <= '0;
      for (int i = 0; i < 8; i++) fbuf[i] <= 4'h0;
      sum         <= 8'h00;
      candy_sum   <= 3'd0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
      seq_err     <= 1'b0;
      err_count   <= '0;
    end else begin
      frame_valid <= 1'b0;
      seq_err     <= 1'b0;
      case (state)
        HUNT: begin
          if (valid && idx == 3'd0 && ok) begin
            fbuf[0] <= dat_q;
            exp_idx <= 3'd1;
            tmo     <= '0;
            state   <= CAPTURE;
            locked  <= 1'b1;
          end
        end
        CAPTURE: begin
          if (valid && idx == exp_idx && ok) begin
            fbuf[idx] <= dat_q;
            tmo       <= '0;
            if (exp_idx == 3'd7) begin
              // cols 3,4,6 are already buffered; col 8 is not used
              sum         <= {fbuf[3], fbuf[2]};
              candy_sum   <= fbuf[5][2:0];
              frame_valid <= 1'b1;
              exp_idx     <= 3'd0;
            end else begin
              exp_idx <= exp_idx + 3'd1;
            end
          end else if (blank) begin
            if (tmo == TW'(TIMEOUT - 1)) begin
              state   <= HUNT;
              locked  <= 1'b0;
              tmo     <= '0;
              exp_idx <= 3'd0;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end else begin
            seq_err <= 1'b1;
            tmo     <= '0;
            if (err_count != '1) err_count <= err_count + 1'b1;
            // a clean column 1 restarts the frame without dropping lock
            if (valid && idx == 3'd0 && ok) begin
              fbuf[0] <= dat_q;
              exp_idx <= 3'd1;
            end else begin
              state   <= HUNT;
              locked  <= 1'b0;
              exp_idx <= 3'd0;
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_capture.sv
// Directed bench for seven_seg_scan_capture.
// Ports: none; drives the scan interface and checks the recovered outputs.
module tb_seven_seg_scan_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] sum;
  logic [2:0] candy_sum;
  logic       frame_valid;
  logic       locked;
  logic       seq_err;
  logic [7:0] err_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fv_cnt = 0;
  int se_cnt = 0;
  int unl_cnt = 0;
  int both_cnt = 0;
  int fv_cyc = 0;
  int fv_prev = 0;

  localparam logic [31:0] F_CLEAN = 32'hAA3A2500;
  localparam logic [31:0] F_ALT   = 32'hAA5A4700;
  localparam logic [31:0] F_BAD5  = 32'hAA332500;

  seven_seg_scan_if bus ();

  seven_seg_scan_capture #(
    .TIMEOUT (16),
    .ERR_W   (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .sum         (sum),
    .candy_sum   (candy_sum),
    .frame_valid (frame_valid),
    .locked      (locked),
    .seq_err     (seq_err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_valid) begin
      fv_cnt  <= fv_cnt + 1;
      fv_prev <= fv_cyc;
      fv_cyc  <= cyc;
    end
    if (seq_err) se_cnt <= se_cnt + 1;
    if (!locked) unl_cnt <= unl_cnt + 1;
    if (frame_valid && seq_err) both_cnt <= both_cnt + 1;
  end

  task automatic step_raw(input logic [7:0] c, input logic [3:0] d);
    @(negedge clk);
    bus.col_n = c;
    bus.data_in = d;
  endtask

  task automatic step(input int col, input logic [3:0] d);
    logic [7:0] c;
    c = (col == 0) ? 8'hFF : ~(8'h01 << (col - 1));
    step_raw(c, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 4'h0);
  endtask

  task automatic send_cols(input logic [31:0] f, input int from, input int to);
    for (int c = from; c <= to; c++) step(c, f[4*(c-1) +: 4]);
  endtask

  task automatic do_reset;
    @(negedge clk);
    bus.col_n = 8'hFF;
    bus.data_in = 4'h0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    idle(1);
    checks++;
    if (sum !== 8'h00 || candy_sum !== 3'd0) begin
      failures++;
      $display("FAIL reset_sums sum=%h candy=%h want 00/0", sum, candy_sum);
    end
    checks++;
    if (frame_valid !== 1'b0 || locked !== 1'b0 || seq_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags fv=%b lk=%b se=%b want 0", frame_valid, locked, seq_err);
    end
    checks++;
    if (err_count !== 8'h00) begin
      failures++;
      $display("FAIL reset_errcnt got=%h want 00", err_count);
    end
  endtask

  task automatic test_clean_frames;
    int fv0, se0, c1;
    do_reset();
    fv0 = fv_cnt;
    se0 = se_cnt;
    step(1, F_CLEAN[3:0]);
    c1 = cyc + 1;
    send_cols(F_CLEAN, 2, 8);
    send_cols(F_CLEAN, 1, 8);
    idle(3);
    checks++;
    if (fv_cnt - fv0 !== 2) begin
      failures++;
      $display("FAIL clean_fv_count got=%0d want 2", fv_cnt - fv0);
    end
    checks++;
    if (fv_cyc - fv_prev !== 8) begin
      failures++;
      $display("FAIL clean_fv_spacing got=%0d want 8", fv_cyc - fv_prev);
    end
    checks++;
    if (fv_prev !== c1 + 8) begin
      failures++;
      $display("FAIL clean_first_latency got=%0d want %0d", fv_prev, c1 + 8);
    end
    checks++;
    if (sum !== 8'h25 || candy_sum !== 3'd3) begin
      failures++;
      $display("FAIL clean_values sum=%h candy=%h want 25/3", sum, candy_sum);
    end
    checks++;
    if (se_cnt !== se0 || locked !== 1'b1) begin
      failures++;
      $display("FAIL clean_state se=%0d lk=%b want 0/1", se_cnt - se0, locked);
    end
  endtask

  task automatic test_skip;
    int se0;
    do_reset();
    send_cols(F_CLEAN, 1, 8);
    se0 = se_cnt;
    step(1, 4'h0);
    step(2, 4'h0);
    step(4, 4'h9);
    idle(3);
    checks++;
    if (se_cnt - se0 !== 1 || err_count !== 8'd1) begin
      failures++;
      $display("FAIL skip_err se=%0d cnt=%0d want 1/1", se_cnt - se0, err_count);
    end
    checks++;
    if (locked !== 1'b0 || sum !== 8'h25) begin
      failures++;
      $display("FAIL skip_state lk=%b sum=%h want 0/25", locked, sum);
    end
  endtask

  task automatic test_gap;
    int fv0, se0;
    do_reset();
    fv0 = fv_cnt;
    send_cols(F_CLEAN, 1, 3);
    idle(15);
    send_cols(F_CLEAN, 4, 8);
    idle(3);
    checks++;
    if (fv_cnt - fv0 !== 1 || sum !== 8'h25 || candy_sum !== 3'd3) begin
      failures++;
      $display("FAIL gap15 fv=%0d sum=%h candy=%h want 1/25/3", fv_cnt - fv0, sum, candy_sum);
    end
    fv0 = fv_cnt;
    se0 = se_cnt;
    send_cols(F_ALT, 1, 3);
    idle(16);
    idle(2);
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL gap16_lock got=%b want 0", locked);
    end
    send_cols(F_ALT, 4, 8);
    idle(3);
    checks++;
    if (fv_cnt !== fv0 || se_cnt !== se0 || sum !== 8'h25) begin
      failures++;
      $display("FAIL gap16_events fv=%0d se=%0d sum=%h want 0/0/25", fv_cnt - fv0, se_cnt - se0, sum);
    end
  endtask

  task automatic test_malformed_resync;
    int fv0, se0, ul0;
    do_reset();
    fv0 = fv_cnt;
    se0 = se_cnt;
    send_cols(F_ALT, 1, 2);
    step_raw(8'hFC, 4'h0);
    send_cols(F_ALT, 1, 8);
    idle(3);
    checks++;
    if (se_cnt - se0 !== 1 || fv_cnt - fv0 !== 1) begin
      failures++;
      $display("FAIL malformed se=%0d fv=%0d want 1/1", se_cnt - se0, fv_cnt - fv0);
    end
    checks++;
    if (sum !== 8'h47 || candy_sum !== 3'd5) begin
      failures++;
      $display("FAIL malformed_values sum=%h candy=%h want 47/5", sum, candy_sum);
    end
    fv0 = fv_cnt;
    se0 = se_cnt;
    ul0 = unl_cnt;
    send_cols(F_CLEAN, 1, 3);
    send_cols(F_CLEAN, 1, 8);
    idle(3);
    checks++;
    if (se_cnt - se0 !== 1 || unl_cnt !== ul0) begin
      failures++;
      $display("FAIL resync se=%0d unlocked_cycles=%0d want 1/0", se_cnt - se0, unl_cnt - ul0);
    end
    checks++;
    if (fv_cnt - fv0 !== 1 || sum !== 8'h25) begin
      failures++;
      $display("FAIL resync_frame fv=%0d sum=%h want 1/25", fv_cnt - fv0, sum);
    end
  endtask

  task automatic test_content;
    int fv0, se0;
    do_reset();
    fv0 = fv_cnt;
    se0 = se_cnt;
    send_cols(F_BAD5, 1, 8);
    idle(3);
`ifdef SCAN_CAP_CONTENT_CHECK_EN
    checks++;
    if (se_cnt - se0 !== 1 || fv_cnt !== fv0 || locked !== 1'b0) begin
      failures++;
      $display("FAIL content se=%0d fv=%0d lk=%b want 1/0/0", se_cnt - se0, fv_cnt - fv0, locked);
    end
`else
    checks++;
    if (se_cnt !== se0 || fv_cnt - fv0 !== 1 || sum !== 8'h25) begin
      failures++;
      $display("FAIL content se=%0d fv=%0d sum=%h want 0/1/25", se_cnt - se0, fv_cnt - fv0, sum);
    end
`endif
  endtask

  task automatic test_reset_mid;
    do_reset();
    send_cols(F_CLEAN, 1, 8);
    step(1, 4'h0);
    step(3, 4'h5);
    send_cols(F_CLEAN, 1, 3);
    idle(1);
    checks++;
    if (locked !== 1'b1 || err_count !== 8'd1 || sum !== 8'h25) begin
      failures++;
      $display("FAIL premid lk=%b cnt=%0d sum=%h want 1/1/25", locked, err_count, sum);
    end
    send_cols(F_CLEAN, 4, 5);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (sum !== 8'h00 || candy_sum !== 3'd0 || err_count !== 8'h00) begin
      failures++;
      $display("FAIL midreset_vals sum=%h candy=%h cnt=%h want 0", sum, candy_sum, err_count);
    end
    checks++;
    if (locked !== 1'b0 || frame_valid !== 1'b0 || seq_err !== 1'b0) begin
      failures++;
      $display("FAIL midreset_flags lk=%b fv=%b se=%b want 0", locked, frame_valid, seq_err);
    end
    @(negedge clk);
    reset = 1'b0;
    send_cols(F_CLEAN, 6, 8);
    idle(3);
    checks++;
    if (locked !== 1'b0 || sum !== 8'h00) begin
      failures++;
      $display("FAIL postreset lk=%b sum=%h want 0/00", locked, sum);
    end
  endtask

  task automatic test_saturation;
    int se0;
    do_reset();
    se0 = se_cnt;
    for (int i = 0; i < 255; i++) step(1, 4'h0);
    idle(3);
    checks++;
    if (err_count !== 8'hFE) begin
      failures++;
      $display("FAIL sat_254 got=%h want fe", err_count);
    end
    for (int i = 0; i < 46; i++) step(1, 4'h0);
    idle(3);
    checks++;
    if (err_count !== 8'hFF || se_cnt - se0 !== 300) begin
      failures++;
      $display("FAIL sat_300 cnt=%h se=%0d want ff/300", err_count, se_cnt - se0);
    end
  endtask

  task automatic test_exclusive;
    checks++;
    if (both_cnt !== 0) begin
      failures++;
      $display("FAIL exclusive got=%0d want 0", both_cnt);
    end
  endtask

  initial begin
    bus.col_n = 8'hFF;
    bus.data_in = 4'h0;
    reset = 1'b1;
    #1;
    test_reset();
    test_clean_frames();
    test_skip();
    test_gap();
    test_malformed_resync();
    test_content();
    test_reset_mid();
    test_saturation();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
